// File: rtl/demux_1x13_reg_if.sv
// Bundles the 13-way write demux data, control and status signals.
// The master drives writes and burst words; the slave is the register bank.
interface demux_1x13_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic [3:0]       sel;
    logic             we;
    logic             clr;
    logic             burst_start;
    logic             burst_valid;
    logic [WIDTH-1:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12;
    logic [12:0]      wstb;
    logic             err;
    logic             busy;
    logic             done;

    modport master (
        output d, sel, we, clr, burst_start, burst_valid,
        input  q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12,
        input  wstb, err, busy, done
    );

    modport slave (
        input  d, sel, we, clr, burst_start, burst_valid,
        output q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12,
        output wstb, err, busy, done
    );
endinterface

// File: rtl/demux_1x13_reg.sv
// Routes one byte per cycle into a bank of 13 registered channels, either
// by explicit channel index or as an in-order 13-word burst load.
module demux_1x13_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic               clock,
    input logic               reset,
    demux_1x13_reg_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BURST, FIN} state_t;

    state_t           state, stateNext;
    logic [3:0]       index, indexNext;
    logic [WIDTH-1:0] bank     [13];
    logic [WIDTH-1:0] bankNext [13];
    logic [12:0]      wstb, wstbNext;
    logic             err, errNext;
    logic             busy, busyNext;
    logic             done, doneNext;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= stateNext;
            index <= indexNext;
        end
    end

    // The burst index wraps back to 0 on the last word so it never exceeds 12.
    always_comb begin
        stateNext = state;
        indexNext = index;
        if (bus.clr) begin
            stateNext = IDLE;
            indexNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.burst_start) begin
                        stateNext = BURST;
                        indexNext = '0;
                    end
                end
                BURST: begin
                    if (bus.burst_valid) begin
                        if (index == 4'd12) begin
                            stateNext = FIN;
                            indexNext = '0;
                        end else begin
                            indexNext = index + 4'd1;
                        end
                    end
                end
                FIN:     stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        bankNext = bank;
        wstbNext = '0;
        errNext  = 1'b0;
        busyNext = (stateNext == BURST);
        doneNext = (stateNext == FIN);
        if (bus.clr) begin
            for (int i = 0; i < 13; i++) begin
                bankNext[i] = RESET_VALUE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.burst_start && bus.we) begin
                        if (bus.sel <= 4'd12) begin
                            bankNext[bus.sel] = bus.d;
                            wstbNext          = 13'b1 << bus.sel;
                        end else begin
                            errNext = 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (bus.burst_valid) begin
                        bankNext[index] = bus.d;
                        wstbNext        = 13'b1 << index;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 13; i++) begin
                bank[i] <= RESET_VALUE;
            end
            wstb <= '0;
            err  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            bank <= bankNext;
            wstb <= wstbNext;
            err  <= errNext;
            busy <= busyNext;
            done <= doneNext;
        end
    end

    assign bus.q0   = bank[0];
    assign bus.q1   = bank[1];
    assign bus.q2   = bank[2];
    assign bus.q3   = bank[3];
    assign bus.q4   = bank[4];
    assign bus.q5   = bank[5];
    assign bus.q6   = bank[6];
    assign bus.q7   = bank[7];
    assign bus.q8   = bank[8];
    assign bus.q9   = bank[9];
    assign bus.q10  = bank[10];
    assign bus.q11  = bank[11];
    assign bus.q12  = bank[12];
    assign bus.wstb = wstb;
    assign bus.err  = err;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_demux_1x13_reg.sv
// Scoreboard bench for demux_1x13_reg: a behavioural model queues the expected
// post-edge outputs per cycle and a monitor compares them against the DUT.
module tb_demux_1x13_reg;
    localparam int W = 8;

    typedef struct packed {
        logic [12:0][W-1:0] q;
        logic [12:0]        wstb;
        logic               err;
        logic               busy;
        logic               done;
    } exp_t;

    logic clock;
    logic reset;
    demux_1x13_reg_if #(.WIDTH(W)) bus ();

    demux_1x13_reg #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: pos = -1 when idle, 0..12 = next burst slot, 13 = the single finish cycle.
    logic [W-1:0] model [13];
    int           pos = -1;

    always #5 clock = ~clock;

    task automatic modelStep(input logic rst, input logic clr, input logic bs,
                             input logic bv, input logic we, input logic [3:0] sel,
                             input logic [W-1:0] d);
        exp_t e;
        e.wstb = '0;
        e.err  = 1'b0;
        if (rst || clr) begin
            for (int i = 0; i < 13; i++) model[i] = '0;
            pos = -1;
        end else if (pos == 13) begin
            pos = -1;
        end else if (pos >= 0) begin
            if (bv) begin
                model[pos] = d;
                e.wstb[pos] = 1'b1;
                pos = pos + 1;
            end
        end else if (bs) begin
            pos = 0;
        end else if (we) begin
            if (int'(sel) < 13) begin
                model[sel] = d;
                e.wstb[sel] = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end
        e.busy = (pos >= 0 && pos <= 12);
        e.done = (pos == 13);
        for (int i = 0; i < 13; i++) e.q[i] = model[i];
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic rst, input logic clr, input logic bs,
                                 input logic bv, input logic we, input logic [3:0] sel,
                                 input logic [W-1:0] d);
        @(negedge clock);
        reset           = rst;
        bus.clr         = clr;
        bus.burst_start = bs;
        bus.burst_valid = bv;
        bus.we          = we;
        bus.sel         = sel;
        bus.d           = d;
        modelStep(rst, clr, bs, bv, we, sel, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 4'd0, '0);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [12:0][W-1:0] act;
        act = {bus.q12, bus.q11, bus.q10, bus.q9, bus.q8, bus.q7, bus.q6,
               bus.q5, bus.q4, bus.q3, bus.q2, bus.q1, bus.q0};
        checks++;
        if (act !== e.q) begin
            failures++;
            $display("[TB] FAIL bank @%0t got=%h exp=%h", $time, act, e.q);
        end
        checks++;
        if (bus.wstb !== e.wstb) begin
            failures++;
            $display("[TB] FAIL wstb @%0t got=%h exp=%h", $time, bus.wstb, e.wstb);
        end
        checks++;
        if (bus.err !== e.err) begin
            failures++;
            $display("[TB] FAIL err @%0t got=%b exp=%b", $time, bus.err, e.err);
        end
        checks++;
        if (bus.busy !== e.busy) begin
            failures++;
            $display("[TB] FAIL busy @%0t got=%b exp=%b", $time, bus.busy, e.busy);
        end
        checks++;
        if (bus.done !== e.done) begin
            failures++;
            $display("[TB] FAIL done @%0t got=%b exp=%b", $time, bus.done, e.done);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        clock           = 1'b0;
        reset           = 1'b1;
        bus.clr         = 1'b0;
        bus.burst_start = 1'b0;
        bus.burst_valid = 1'b0;
        bus.we          = 1'b0;
        bus.sel         = 4'd0;
        bus.d           = '0;

        applyStimulus(1, 0, 0, 0, 0, 4'd0, '0);
        applyStimulus(1, 0, 0, 0, 1, 4'd3, 8'h77);
        // Single write to channel 5, then an out-of-range write.
        applyStimulus(0, 0, 0, 0, 1, 4'd5, 8'hA5);
        idle(1);
        applyStimulus(0, 0, 0, 0, 1, 4'hD, 8'hFF);
        applyStimulus(0, 0, 0, 0, 1, 4'hF, 8'hEE);
        idle(1);
        // Full burst 10..1C with valid held high.
        applyStimulus(0, 0, 1, 0, 0, 4'd0, '0);
        for (int i = 0; i < 13; i++) applyStimulus(0, 0, 0, 1, 1, 4'hE, 8'h10 + 8'(i));
        idle(2);
        // Burst with a 3-cycle stall after word 6; start shares a cycle with WE to Q2.
        applyStimulus(0, 0, 1, 0, 1, 4'd2, 8'h99);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 4'd0, 8'h40 + 8'(i));
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1, 4'd1, 8'hBB);
        for (int i = 7; i < 13; i++) applyStimulus(0, 0, 0, 1, 0, 4'd0, 8'h40 + 8'(i));
        idle(2);
        // Abort mid-burst with CLR, then with reset.
        applyStimulus(0, 0, 1, 0, 0, 4'd0, '0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 4'd0, 8'h60 + 8'(i));
        applyStimulus(0, 1, 0, 1, 0, 4'd0, 8'h67);
        idle(2);
        applyStimulus(0, 0, 1, 0, 0, 4'd0, '0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0, 4'd0, 8'h70 + 8'(i));
        applyStimulus(1, 0, 0, 1, 0, 4'd0, 8'h77);
        idle(2);
        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom), 4'($urandom), W'($urandom));
        end
        idle(2);
        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d exp=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
